// File: rtl/cpu_control_fsm.sv
// Instruction register plus Moore control sequencer for the 16-bit datapath.
// Decodes the latched word and walks it through read/ALU/writeback states.
module cpu_control_fsm #(
  parameter logic [15:0] IR_RESET = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] in,
  input  logic        load,
  input  logic        s,
  output logic        w,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        write,
  output logic [1:0]  vsel,
  output logic        asel,
  output logic        bsel,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic [15:0] sximm5,
  output logic [15:0] sximm8
);

  typedef enum logic [2:0] {
    S_WAIT      = 3'd0,
    S_DECODE    = 3'd1,
    S_WRITE_IMM = 3'd2,
    S_GET_A     = 3'd3,
    S_GET_B     = 3'd4,
    S_ALU       = 3'd5,
    S_WRITE_REG = 3'd6
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] ir_q, ir_d;

  logic [2:0] opcode, rn, rd, rm;
  logic [1:0] op, sh;
  logic       is_mov_imm, is_mov_reg, is_mvn, is_alu3, is_cmp;

  assign opcode = ir_q[15:13];
  assign op     = ir_q[12:11];
  assign rn     = ir_q[10:8];
  assign rd     = ir_q[7:5];
  assign sh     = ir_q[4:3];
  assign rm     = ir_q[2:0];

  assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
  assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
  assign is_mvn     = (opcode == 3'b101) && (op == 2'b11);
  assign is_alu3    = (opcode == 3'b101) && (op != 2'b11);
  assign is_cmp     = (opcode == 3'b101) && (op == 2'b01);

  assign sximm5 = {{11{ir_q[4]}}, ir_q[4:0]};
  assign sximm8 = {{8{ir_q[7]}}, ir_q[7:0]};

  // IR is only writable in WAIT, so DECODE always sees the word captured
  // on the same edge that sampled s.
  always_comb begin
    state_d = S_WAIT;
    ir_d    = ir_q;
    case (state_q)
      S_WAIT: begin
        if (load) ir_d = in;
        state_d = s ? S_DECODE : S_WAIT;
      end
      S_DECODE: begin
        if (is_mov_imm)                state_d = S_WRITE_IMM;
        else if (is_mov_reg || is_mvn) state_d = S_GET_B;
        else if (is_alu3)              state_d = S_GET_A;
        else                           state_d = S_WAIT;
      end
      S_WRITE_IMM: state_d = S_WAIT;
      S_GET_A:     state_d = S_GET_B;
      S_GET_B:     state_d = S_ALU;
      S_ALU:       state_d = is_cmp ? S_WAIT : S_WRITE_REG;
      S_WRITE_REG: state_d = S_WAIT;
      default:     state_d = S_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_WAIT;
      ir_q    <= IR_RESET;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    w        = 1'b0;
    readnum  = rn;
    writenum = rn;
    write    = 1'b0;
    vsel     = 2'b00;
    asel     = 1'b0;
    bsel     = 1'b0;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    shift    = 2'b00;
    ALUop    = 2'b00;
    case (state_q)
      S_WAIT: w = 1'b1;
      S_WRITE_IMM: begin
        writenum = rn;
        vsel     = 2'b01;
        write    = 1'b1;
      end
      S_GET_A: begin
        readnum = rn;
        loada   = 1'b1;
      end
      S_GET_B: begin
        readnum = rm;
        loadb   = 1'b1;
      end
      S_ALU: begin
        shift = sh;
        loadc = 1'b1;
        // MOV reg passes shifted B through an add with a zeroed A operand
        asel  = is_mov_reg;
        ALUop = is_mov_reg ? 2'b00 : op;
        loads = is_cmp;
      end
      S_WRITE_REG: begin
        writenum = rd;
        vsel     = 2'b11;
        write    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Scoreboard bench: an instruction-level model queues the expected control
// vector for every edge; a monitor compares it against the DUT after the edge.
module tb_cpu_control_fsm;

  typedef struct packed {
    logic        w;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        write;
    logic [1:0]  vsel;
    logic        asel;
    logic        bsel;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic [1:0]  shift;
    logic [1:0]  aluop;
    logic [15:0] sximm5;
    logic [15:0] sximm8;
  } ctl_t;

  logic        clk = 1'b0;
  logic        reset, load, s;
  logic [15:0] in;
  logic        w, write, asel, bsel, loada, loadb, loadc, loads;
  logic [2:0]  readnum, writenum;
  logic [1:0]  vsel, shift, aluop;
  logic [15:0] sximm5, sximm8;
  ctl_t        act;

  int total = 0;
  int bad   = 0;
  int ncyc  = 0;

  ctl_t        expq[$];
  ctl_t        plan[$];
  logic [15:0] m_ir;

  cpu_control_fsm #(.IR_RESET(16'h0000)) dut (
    .clk(clk), .reset(reset), .in(in), .load(load), .s(s), .w(w),
    .readnum(readnum), .writenum(writenum), .write(write), .vsel(vsel),
    .asel(asel), .bsel(bsel), .loada(loada), .loadb(loadb), .loadc(loadc),
    .loads(loads), .shift(shift), .ALUop(aluop), .sximm5(sximm5), .sximm8(sximm8)
  );

  always #5 clk = ~clk;

  assign act = {w, readnum, writenum, write, vsel, asel, bsel, loada, loadb,
                loadc, loads, shift, aluop, sximm5, sximm8};

  function automatic ctl_t base_ctl(input logic [15:0] ir);
    ctl_t c;
    c          = '0;
    c.readnum  = ir[10:8];
    c.writenum = ir[10:8];
    c.sximm5   = {{11{ir[4]}}, ir[4:0]};
    c.sximm8   = {{8{ir[7]}}, ir[7:0]};
    return c;
  endfunction

  function automatic ctl_t idle_ctl(input logic [15:0] ir);
    ctl_t c;
    c   = base_ctl(ir);
    c.w = 1'b1;
    return c;
  endfunction

  // Expected per-cycle control sequence of one instruction, from DECODE on.
  task automatic build_plan(input logic [15:0] ir);
    ctl_t   b, c;
    string  kind;
    b = base_ctl(ir);
    plan.delete();
    plan.push_back(b);
    case (ir[15:11])
      5'b11010: kind = "movi";
      5'b11000: kind = "movr";
      5'b10111: kind = "mvn";
      5'b10100: kind = "add";
      5'b10101: kind = "cmp";
      5'b10110: kind = "and";
      default:  kind = "none";
    endcase
    if (kind == "movi") begin
      c = b; c.vsel = 2'b01; c.write = 1'b1; plan.push_back(c);
    end else if (kind != "none") begin
      if (kind == "add" || kind == "cmp" || kind == "and") begin
        c = b; c.loada = 1'b1; plan.push_back(c);
      end
      c = b; c.readnum = ir[2:0]; c.loadb = 1'b1; plan.push_back(c);
      c = b; c.shift = ir[4:3]; c.loadc = 1'b1;
      c.asel  = (kind == "movr");
      c.aluop = (kind == "movr") ? 2'b00 : ir[12:11];
      c.loads = (kind == "cmp");
      plan.push_back(c);
      if (kind != "cmp") begin
        c = b; c.writenum = ir[7:5]; c.vsel = 2'b11; c.write = 1'b1; plan.push_back(c);
      end
    end
  endtask

  task automatic model_step(input logic r, input logic l, input logic [15:0] d, input logic sv);
    if (r) begin
      plan.delete();
      m_ir = 16'h0000;
    end else if (plan.size() != 0) begin
      void'(plan.pop_front());
    end else begin
      if (l) m_ir = d;
      if (sv) build_plan(m_ir);
    end
    expq.push_back(plan.size() != 0 ? plan[0] : idle_ctl(m_ir));
  endtask

  task automatic cyc(input logic r, input logic l, input logic [15:0] d, input logic sv);
    @(negedge clk);
    reset = r; load = l; in = d; s = sv;
    model_step(r, l, d, sv);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 16'h0000, 1'b0);
  endtask

  task automatic run(input logic [15:0] ir, input int n);
    cyc(1'b0, 1'b1, ir, 1'b0);
    cyc(1'b0, 1'b0, 16'h0000, 1'b1);
    idle(n);
  endtask

  function automatic logic [15:0] rand_instr();
    logic [15:0] tmpl [6];
    logic [15:0] r;
    tmpl[0] = 16'hD000; tmpl[1] = 16'hC000; tmpl[2] = 16'hB800;
    tmpl[3] = 16'hA000; tmpl[4] = 16'hA800; tmpl[5] = 16'hB000;
    r = 16'($urandom());
    if ($urandom_range(0, 7) == 0) return r;
    return tmpl[$urandom_range(0, 5)] | (r & 16'h07FF);
  endfunction

  initial begin : monitor
    ctl_t e;
    forever begin
      @(posedge clk);
      #1;
      ncyc++;
      if (expq.size() != 0) begin
        e = expq.pop_front();
        total++;
        if (act !== e) begin
          bad++;
          $display("FAIL ctl cyc=%0d got=%h exp=%h (w=%b wr=%b wn=%0d rn=%0d ld=%b%b%b%b)",
                   ncyc, act, e, w, write, writenum, readnum, loada, loadb, loadc, loads);
        end
      end
    end
  end

  initial begin : driver
    reset = 1'b1; load = 1'b0; s = 1'b0; in = 16'h0000; m_ir = 16'h0000;
    cyc(1'b1, 1'b0, 16'h0000, 1'b0);
    cyc(1'b1, 1'b0, 16'h0000, 1'b0);
    idle(5);
    cyc(1'b0, 1'b1, 16'hD107, 1'b1);
    idle(3);
    run(16'hA148, 7);
    run(16'hA900, 6);
    run(16'hB860, 6);
    run(16'h0000, 3);
    run(16'hD2FF, 4);
    run(16'hC00B, 6);
    run(16'hB5B9, 7);
    // reset while in GET_B
    cyc(1'b0, 1'b1, 16'hA148, 1'b0);
    cyc(1'b0, 1'b0, 16'h0000, 1'b1);
    idle(2);
    cyc(1'b1, 1'b0, 16'h0000, 1'b0);
    idle(3);
    // load attempted while in GET_A is ignored
    cyc(1'b0, 1'b1, 16'hA148, 1'b0);
    cyc(1'b0, 1'b0, 16'h0000, 1'b1);
    idle(1);
    cyc(1'b0, 1'b1, 16'hD2FF, 1'b0);
    idle(6);
    // s held high: back-to-back repeats with one WAIT cycle between
    cyc(1'b0, 1'b1, 16'hA148, 1'b0);
    for (int i = 0; i < 14; i++) cyc(1'b0, 1'b0, 16'h0000, 1'b1);
    idle(6);
    for (int i = 0; i < 500; i++)
      cyc($urandom_range(0, 79) == 0, $urandom_range(0, 3) == 0, rand_instr(),
          $urandom_range(0, 2) == 0);
    idle(8);
    @(posedge clk);
    #3;
    total++;
    if (expq.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d exp=0 pending expectations", expq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
